twos_complement_serial: RTL and testbench
=========================================

TWOS_COMPLEMENT_SERIAL -- requirements
Module: twos_complement_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 34, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter CHUNK, default 8, bits processed per cycle (1 <= CHUNK <= WIDTH); NBEATS = ceil(WIDTH/CHUNK).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand offered.
REQ-006 SHALL have port in_ready  output  1  unit can accept an operand.
REQ-007 SHALL have port mode  input  2  00 invert, 01 negate, 10 absolute value, 11 pass-through.
REQ-008 SHALL have port x  input  WIDTH  operand, two's complement.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port xout  output  WIDTH  result.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-014 IDLE: on in_valid & in_ready SHALL capture x and mode, clear beat counter, enter RUN.
REQ-015 At capture SHALL set invert flag = (mode==00) | (mode==01) | (mode==10 & x[WIDTH-1]); carry-in = (mode==01) | (mode==10 & x[WIDTH-1]).
REQ-016 RUN: each cycle SHALL compute chunk k = (invert ? ~x_chunk : x_chunk) + carry, store it in xout bits [k*CHUNK +: CHUNK], propagate carry to chunk k+1.
REQ-017 Final chunk SHALL be WIDTH - (NBEATS-1)*CHUNK bits wide; carry out of bit WIDTH-1 SHALL be discarded.
REQ-018 After beat NBEATS-1 SHALL enter DONE; out_valid asserts exactly NBEATS cycles after accepting edge, in every mode including 11.
REQ-019 DONE: out_valid = 1, xout held stable until out_ready; on out_valid & out_ready SHALL return to IDLE next cycle; no same-cycle accept of a new operand.
REQ-020 in_valid, x, mode SHALL be ignored outside IDLE; x/mode changes after capture SHALL not affect the result.
REQ-021 Negate/abs of most-negative value (1 followed by zeros) SHALL yield the input value unchanged (wrap-around).
REQ-022 xout SHALL be don't-care-free: it holds the last completed result while in IDLE.

Reset
REQ-023 reset SHALL force state IDLE, in_ready = 1, out_valid = 0, busy = 0, xout = 0, beat counter = 0, carry = 0 on the next edge.
REQ-024 reset mid-RUN or in DONE SHALL abort the operation and discard the partial result; reset has priority over all handshakes.

Configuration
REQ-025 Macro TWOS_COMPLEMENT_SERIAL_OVF_EN SHALL, when defined, add output ovf (1 bit), valid with out_valid: 1 iff mode is 01 or 10 and captured x is most-negative; cleared by reset and on leaving DONE.
REQ-026 Without TWOS_COMPLEMENT_SERIAL_OVF_EN port ovf SHALL not exist and no overflow logic SHALL be built; all other behaviour is identical.

Verification
REQ-027 WIDTH=34, CHUNK=8, mode 01, x=0x000000001 -> xout=0x3FFFFFFFF, out_valid rises exactly 5 cycles after accept.
REQ-028 mode 00, x=0 -> xout=0x3FFFFFFFF; mode 01, x=0 -> xout=0, ovf=0; mode 11, x=0x123456789 -> 0x123456789 after 5 cycles.
REQ-029 mode 10, x=0x3FFFFFFFB (-5) -> 5; mode 10, x=5 -> 5; mode 01, x=0x200000000 -> 0x200000000 with ovf=1 (macro defined), no ovf port (undefined).
REQ-030 out_ready held low 3 cycles in DONE -> xout stable, out_valid=1, in_ready=0, new in_valid ignored; out_ready=1 -> in_ready=1 following cycle.
REQ-031 reset asserted in third RUN beat -> next cycle out_valid=0, in_ready=1, busy=0, xout=0; next operand processes correctly.
REQ-032 WIDTH=10, CHUNK=4 (3 beats, 2-bit top chunk), mode 01, x=0x001 -> xout=0x3FF after 3 cycles; x=0x200 -> 0x200, ovf=1.

Source files
------------

// File: rtl/twos_complement_serial.sv
// Serial two's-complement unit: invert / negate / absolute value / pass-through,
// processed CHUNK bits per cycle, least significant chunk first.
// Optional overflow flag output built when TWOS_COMPLEMENT_SERIAL_OVF_EN is defined.
module twos_complement_serial #(
   parameter int WIDTH = 34,
   parameter int CHUNK = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] xout,
   output logic             busy
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NBEATS = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] opnd;      // captured operand, shifted down one chunk per beat
   logic [WIDTH-1:0] res;       // result, filled chunk by chunk
   logic [CW-1:0]    beat;
   logic             inv;
   logic             carry;
   logic             last_beat;
   logic [CHUNK-1:0] chunk_in;
   logic [CHUNK:0]   sum;

   assign last_beat = (beat == CW'(NBEATS - 1));
   assign xout      = res;

   // Current chunk: bits above WIDTH in the final beat read as zero after shifting,
   // and whatever they turn into is never stored.
   always_comb begin
      chunk_in = opnd[CHUNK-1:0];
      sum      = {1'b0, (inv ? ~chunk_in : chunk_in)} + {{CHUNK{1'b0}}, carry};
   end

   // State register; reset wins over every handshake.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_beat) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture the operand and its transform flags, then ripple one chunk per beat.
   always_ff @(posedge clock) begin
      if (reset) begin
         opnd  <= '0;
         res   <= '0;
         beat  <= '0;
         inv   <= 1'b0;
         carry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opnd  <= x;
                  beat  <= '0;
                  inv   <= (mode == 2'b00) || (mode == 2'b01) || ((mode == 2'b10) && x[WIDTH-1]);
                  carry <= (mode == 2'b01) || ((mode == 2'b10) && x[WIDTH-1]);
               end
            end
            RUN: begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (beat == CW'(i / CHUNK)) res[i] <= sum[i % CHUNK];
               end
               opnd  <= opnd >> CHUNK;
               carry <= sum[CHUNK];
               beat  <= last_beat ? '0 : beat + CW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
   logic ovf_flag;

   // Negating the most-negative value wraps back to itself; flag it for the consumer.
   always_ff @(posedge clock) begin
      if (reset) begin
         ovf_flag <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         ovf_flag <= ((mode == 2'b01) || (mode == 2'b10)) &&
                     (x == {1'b1, {(WIDTH-1){1'b0}}});
      end else if (state == DONE && out_ready) begin
         ovf_flag <= 1'b0;
      end
   end

   assign ovf = ovf_flag && (state == DONE);
`endif

endmodule

// File: tb/tb_twos_complement_serial.sv
// Self-checking bench: a transaction-level reference model tracks what the
// outputs must be every cycle; directed cases pin known literal results.
module tb_twos_complement_serial;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [1:0]  mode;
   logic [33:0] x, xout;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
   logic [1:0]  s_mode;
   logic [9:0]  s_x, s_xout;

`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
   logic        ovf, s_ovf;
   logic        lit_ovf = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   twos_complement_serial #(.WIDTH(34), .CHUNK(8)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .x(x), .out_valid(out_valid), .out_ready(out_ready),
      .xout(xout), .busy(busy)
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
      , .ovf(ovf)
`endif
   );

   twos_complement_serial #(.WIDTH(10), .CHUNK(4)) dut_s (
      .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .mode(s_mode), .x(s_x), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .xout(s_xout), .busy(s_busy)
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
      , .ovf(s_ovf)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic on the 34-bit operand.
   function automatic logic [33:0] ref_fn(input logic [1:0] m, input logic [33:0] v);
      case (m)
         2'b00:   return ~v;
         2'b01:   return -v;
         2'b10:   return v[33] ? -v : v;
         default: return v;
      endcase
   endfunction

   // Transaction model: one pending operation, its accept edge and expected result.
   int          cyc = 0;
   bit          active = 0;
   bit          m_pend = 0;
   int          m_acc = 0;
   logic [33:0] m_val = '0;
   logic [33:0] m_last = '0;
   bit          m_ovf = 0;

   always @(posedge clock) begin
      if (reset) begin
         m_pend = 0;
         m_last = '0;
      end else if (!m_pend && in_valid) begin
         m_pend = 1;
         m_acc  = cyc + 1;
         m_val  = ref_fn(mode, x);
         m_ovf  = (mode == 2'b01 || mode == 2'b10) && (x == 34'h200000000);
      end else if (m_pend && cyc >= m_acc + 5 && out_ready) begin
         m_pend = 0;
         m_last = m_val;
      end
      cyc++;
      active = 1;
   end

   // Every-cycle comparison against the model.
   always @(negedge clock) begin
      if (active) begin
         bit ov_exp;
         ov_exp = m_pend && (cyc >= m_acc + 5);
         chk("in_ready", 64'(in_ready), 64'(!m_pend));
         chk("busy", 64'(busy), 64'(m_pend));
         chk("out_valid", 64'(out_valid), 64'(ov_exp));
         if (ov_exp)       chk("xout_result", 64'(xout), 64'(m_val));
         else if (!m_pend) chk("xout_idle", 64'(xout), 64'(m_last));
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
         chk("ovf", 64'(ovf), 64'(ov_exp && m_ovf));
`endif
      end
   end

   // Called at posedge+1 with the main unit idle; returns the same way.
   task automatic op(input logic [1:0] m, input logic [33:0] v, input int hold,
                     input bit pin, input logic [33:0] lit);
      int n;
      in_valid = 1; mode = m; x = v;
      @(posedge clock); #1;
      in_valid = 1; mode = 2'($urandom); x = 34'({$urandom, $urandom});
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      if (!out_valid) chk("op_timeout", 64'(n), 64'(5));
      if (pin) begin
         chk("latency", 64'(n), 64'(5));
         chk("xout_lit", 64'(xout), 64'(lit));
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
         chk("ovf_lit", 64'(ovf), 64'(lit_ovf));
         lit_ovf = 0;
`endif
      end
      repeat (hold) begin
         @(posedge clock); #1;
         x = 34'({$urandom, $urandom});
         if (pin) begin
            chk("hold_xout", 64'(xout), 64'(lit));
            chk("hold_out_valid", 64'(out_valid), 64'(1));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
         end
      end
      in_valid = 0; out_ready = 1;
      @(posedge clock); #1;
      out_ready = 0;
      if (pin) chk("in_ready_after", 64'(in_ready), 64'(1));
   endtask

   task automatic sop(input logic [1:0] m, input logic [9:0] v, input logic [9:0] lit);
      int n;
      s_in_valid = 1; s_mode = m; s_x = v;
      @(posedge clock); #1;
      s_in_valid = 0; s_x = 10'($urandom);
      n = 0;
      while (!s_out_valid && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      chk("s_latency", 64'(n), 64'(3));
      chk("s_xout", 64'(s_xout), 64'(lit));
      chk("s_busy", 64'(s_busy), 64'(1));
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
      chk("s_ovf", 64'(s_ovf), 64'(lit_ovf));
      lit_ovf = 0;
`endif
      s_out_ready = 1;
      @(posedge clock); #1;
      s_out_ready = 0;
      chk("s_in_ready", 64'(s_in_ready), 64'(1));
   endtask

   initial begin
      reset = 1; in_valid = 0; mode = '0; x = '0; out_ready = 0;
      s_in_valid = 0; s_mode = '0; s_x = '0; s_out_ready = 0;
      repeat (2) @(posedge clock);
      #1 reset = 0;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_xout", 64'(xout), 64'(0));

      op(2'b01, 34'h000000001, 0, 1, 34'h3FFFFFFFF);
      op(2'b00, 34'h000000000, 0, 1, 34'h3FFFFFFFF);
      op(2'b01, 34'h000000000, 1, 1, 34'h000000000);
      op(2'b11, 34'h123456789, 0, 1, 34'h123456789);
      op(2'b10, 34'h3FFFFFFFB, 0, 1, 34'h000000005);
      op(2'b10, 34'h000000005, 0, 1, 34'h000000005);
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
      lit_ovf = 1;
`endif
      op(2'b01, 34'h200000000, 0, 1, 34'h200000000);
      op(2'b00, 34'h0F0F0F0F0, 3, 1, 34'h30F0F0F0F);

      // Abort during the third beat, then confirm a clean follow-up operation.
      in_valid = 1; mode = 2'b01; x = 34'h000000123;
      @(posedge clock); #1;
      in_valid = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1;
      @(posedge clock); #1;
      reset = 0;
      chk("abort_out_valid", 64'(out_valid), 64'(0));
      chk("abort_in_ready", 64'(in_ready), 64'(1));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_xout", 64'(xout), 64'(0));
      op(2'b01, 34'h000000002, 0, 1, 34'h3FFFFFFFE);

      sop(2'b01, 10'h001, 10'h3FF);
`ifdef TWOS_COMPLEMENT_SERIAL_OVF_EN
      lit_ovf = 1;
`endif
      sop(2'b01, 10'h200, 10'h200);
      sop(2'b10, 10'h3F6, 10'h00A);
      sop(2'b00, 10'h155, 10'h2AA);

      for (int i = 0; i < 60; i++) begin
         logic [33:0] v;
         case ($urandom_range(0, 3))
            0:       v = 34'h000000000;
            1:       v = 34'h200000000;
            2:       v = 34'h3FFFFFFFF;
            default: v = 34'({$urandom, $urandom});
         endcase
         op(2'($urandom), v, int'($urandom_range(0, 3)), 0, '0);
      end

      repeat (2) @(posedge clock);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
